// File: rtl/colorclk_pkg.sv
// Shared definitions for the colour-subcarrier mode scheduler: FSM encoding,
// DDS increment width, default increments and the {altern,mode} table index.
package colorclk_pkg;

  localparam int INC_W = 29;

  // Scheduler states (plain constants so legacy tools can read them)
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
  localparam logic [1:0] ST_SWITCH    = 2'd2;
  localparam logic [1:0] ST_SETTLE    = 2'd3;

  // Default increments, Fout = Fclk*inc/2^29
  localparam logic [INC_W-1:0] INC_PAL_140  = 29'd68008027;
  localparam logic [INC_W-1:0] INC_NTSC_140 = 29'd54907245;
  localparam logic [INC_W-1:0] INC_PAL_156  = 29'd60935192;
  localparam logic [INC_W-1:0] INC_NTSC_156 = 29'd49196892;

  // Table index: bit 1 = clock source, bit 0 = standard
  function automatic logic [1:0] tbl_idx(input logic altern, input logic mode);
    return {altern, mode};
  endfunction

  function automatic logic [INC_W-1:0] default_inc(input logic [1:0] idx);
    case (idx)
      2'b00:   return INC_PAL_140;
      2'b01:   return INC_NTSC_140;
      2'b10:   return INC_PAL_156;
      default: return INC_NTSC_156;
    endcase
  endfunction

endpackage

// File: rtl/colorclk_if.sv
// Config-side request/ack handshake, table write port and DDS link bundled
// into one interface. master = config logic / DDS, slave = scheduler.
interface colorclk_if;
  import colorclk_pkg::*;

  logic             req;
  logic             req_mode;
  logic             req_altern;
  logic             ack;
  logic             busy;
  logic             acc_msb;
  logic [INC_W-1:0] prescaler;
  logic             mode_cur;
  logic             altern_cur;
  logic             locked;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [INC_W-1:0] cfg_data;

  modport master (
    output req, req_mode, req_altern, acc_msb, cfg_we, cfg_sel, cfg_data,
    input  ack, busy, prescaler, mode_cur, altern_cur, locked
  );

  modport slave (
    input  req, req_mode, req_altern, acc_msb, cfg_we, cfg_sel, cfg_data,
    output ack, busy, prescaler, mode_cur, altern_cur, locked
  );

endinterface

// File: rtl/colorclk_edge_det.sv
// Falling-edge detector on the DDS accumulator MSB. acc_msb comes from the
// same clock domain, so two plain flops are enough (no synchroniser).
module colorclk_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_msb,
  output logic o_fall
);

  logic r_msb_p0;
  logic r_msb_p1;

  // Stage p0: registered MSB; stage p1: previous registered MSB
  always_ff @(posedge clk) begin
    if (reset) begin
      r_msb_p0 <= 1'b0;
      r_msb_p1 <= 1'b0;
    end else begin
      r_msb_p0 <= i_msb;
      r_msb_p1 <= r_msb_p0;
    end
  end

  assign o_fall = r_msb_p1 & ~r_msb_p0;

endmodule

// File: rtl/colorclk_mode_sched.sv
// Colour-clock mode scheduler: accepts mode/clock-source change requests,
// waits for an accumulator MSB falling edge (or a timeout) so the increment
// swap is glitch-free, then reports lock after a settle interval.
module colorclk_mode_sched
  import colorclk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int EDGE_TIMEOUT  = 4096
) (
  input logic       clk,
  input logic       reset,
  colorclk_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int WW = $clog2(EDGE_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(EDGE_TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_lat;
  logic             r_noop;
  logic             r_ack;
  logic             r_busy;
  logic             r_locked;
  logic             r_mode_cur;
  logic             r_altern_cur;
  logic [INC_W-1:0] r_prescaler;
  logic [INC_W-1:0] r_table [4];
  logic [SW-1:0]    r_settle_cnt;
  logic [WW-1:0]    r_wait_cnt;

  logic w_fall;
  logic w_accept;
  logic w_same;

  colorclk_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .i_msb (bus.acc_msb),
    .o_fall(w_fall)
  );

  assign w_accept = bus.req & ~r_busy &
                    ((r_state == ST_IDLE) || (r_state == ST_SETTLE));
  assign w_same   = (tbl_idx(bus.req_altern, bus.req_mode) ==
                     tbl_idx(r_altern_cur, r_mode_cur));

  // Request FSM, increment table and settle/wait counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_SETTLE;
      r_lat        <= 2'b00;
      r_noop       <= 1'b0;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
      r_locked     <= 1'b0;
      r_mode_cur   <= 1'b0;
      r_altern_cur <= 1'b0;
      r_prescaler  <= INC_PAL_140;
      r_settle_cnt <= '0;
      r_wait_cnt   <= '0;
      for (int i = 0; i < 4; i++) r_table[i] <= default_inc(2'(i));
    end else begin
      r_ack <= 1'b0;

      // A zero increment would stop the DDS, so such writes are dropped
      if (bus.cfg_we && (bus.cfg_data != '0)) r_table[bus.cfg_sel] <= bus.cfg_data;

      // Same-mode request: acknowledge one cycle after acceptance
      if (r_noop) begin
        r_noop <= 1'b0;
        r_ack  <= 1'b1;
        r_busy <= 1'b0;
      end

      case (r_state)
        ST_IDLE, ST_SETTLE: begin
          if (r_state == ST_SETTLE) begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_locked <= 1'b1;
              r_state  <= ST_IDLE;
            end else begin
              r_settle_cnt <= r_settle_cnt + SW'(1);
            end
          end
          if (w_accept) begin
            r_lat  <= tbl_idx(bus.req_altern, bus.req_mode);
            r_busy <= 1'b1;
            if (w_same) begin
              r_noop <= 1'b1;
            end else begin
              // Lock status is held as-is until the actual switch
              r_locked   <= r_locked;
              r_state    <= ST_WAIT_EDGE;
              r_wait_cnt <= '0;
            end
          end
        end
        ST_WAIT_EDGE: begin
          if (w_fall || (r_wait_cnt == WAIT_LAST)) begin
            r_state <= ST_SWITCH;
          end else begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
        ST_SWITCH: begin
          r_prescaler  <= r_table[r_lat];
          r_altern_cur <= r_lat[1];
          r_mode_cur   <= r_lat[0];
          r_locked     <= 1'b0;
          r_ack        <= 1'b1;
          r_busy       <= 1'b0;
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end
        default: r_state <= ST_SETTLE;
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.busy       = r_busy;
  assign bus.prescaler  = r_prescaler;
  assign bus.mode_cur   = r_mode_cur;
  assign bus.altern_cur = r_altern_cur;
  assign bus.locked     = r_locked;

endmodule
